ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv_pkg.sv | 52 +++++
 rtl/ex_muldiv_div.sv | 136 +++++++++++++
 rtl/ex_muldiv.sv | 97 +++++++++
 tb/tb_ex_muldiv.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared defines for the execute-stage multiply/divide unit:
// aluop codes, reset level, default datapath width and divider FSM encoding.
package ex_muldiv_pkg;

  localparam logic        RST_ENABLE     = 1'b1;
  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned ALUOP_W        = 8;

  localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = 8'b00000000;
  localparam logic [ALUOP_W-1:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [ALUOP_W-1:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [ALUOP_W-1:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [ALUOP_W-1:0] EXE_DIVU_OP  = 8'b00011011;
  localparam logic [ALUOP_W-1:0] EXE_MADD_OP  = 8'b10100110;
  localparam logic [ALUOP_W-1:0] EXE_MADDU_OP = 8'b10101000;
  localparam logic [ALUOP_W-1:0] EXE_MSUB_OP  = 8'b10101010;
  localparam logic [ALUOP_W-1:0] EXE_MSUBU_OP = 8'b10101011;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  // Decoded view of an aluop as seen by the multiply/divide unit.
  typedef struct packed {
    logic mult;  // single-cycle product to HI/LO
    logic acc;   // two-cycle multiply-accumulate
    logic sub;   // accumulate subtracts the product
    logic div;   // iterative divide
    logic sgn;   // operands are two's complement
  } mdop_t;

  function automatic mdop_t decode_mdop(input logic [ALUOP_W-1:0] op);
    mdop_t d;
    d = '0;
    case (op)
      EXE_MULT_OP:  begin d.mult = 1'b1; d.sgn = 1'b1; end
      EXE_MULTU_OP: begin d.mult = 1'b1; end
      EXE_MADD_OP:  begin d.acc  = 1'b1; d.sgn = 1'b1; end
      EXE_MADDU_OP: begin d.acc  = 1'b1; end
      EXE_MSUB_OP:  begin d.acc  = 1'b1; d.sub = 1'b1; d.sgn = 1'b1; end
      EXE_MSUBU_OP: begin d.acc  = 1'b1; d.sub = 1'b1; end
      EXE_DIV_OP:   begin d.div  = 1'b1; d.sgn = 1'b1; end
      EXE_DIVU_OP:  begin d.div  = 1'b1; end
      default:      ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ex_muldiv_div.sv
// Iterative restoring divider: one quotient bit per cycle on operand
// magnitudes, sign fix-up applied combinationally in the END state.
module ex_div
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_op,
  input  logic              annul,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              stallreq,
  output logic              whilo,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int unsigned       CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

  div_state_e        state_q, state_nxt;
  logic [DATA_W-1:0] a_q, b_q, rem_q, quo_q;
  logic              sgn_q, dz_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [DATA_W-1:0] a_mag, b_mag, rem_step, quo_step, quo_fix, rem_fix;
  logic [DATA_W:0]   shifted, trial;

  // Magnitudes and one restoring step; the divisor magnitude comes from the latched copy.
  always_comb begin
    a_mag   = (signed_op && dividend[DATA_W-1]) ? -dividend : dividend;
    b_mag   = (sgn_q && b_q[DATA_W-1]) ? -b_q : b_q;
    shifted = {rem_q, quo_q[DATA_W-1]};
    trial   = shifted - {1'b0, b_mag};
    if (!trial[DATA_W]) begin
      rem_step = trial[DATA_W-1:0];
      quo_step = {quo_q[DATA_W-2:0], 1'b1};
    end else begin
      rem_step = shifted[DATA_W-1:0];
      quo_step = {quo_q[DATA_W-2:0], 1'b0};
    end
    quo_fix = (sgn_q && (a_q[DATA_W-1] ^ b_q[DATA_W-1])) ? -quo_q : quo_q;
    rem_fix = (sgn_q && a_q[DATA_W-1]) ? -rem_q : rem_q;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) state_q <= DIV_IDLE;
    else                   state_q <= state_nxt;
  end

  // Next-state logic; annul returns any active state to IDLE.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      DIV_IDLE: begin
        if (start && !annul) state_nxt = (divisor == '0) ? DIV_BYZERO : DIV_ON;
      end
      DIV_BYZERO: state_nxt = annul ? DIV_IDLE : DIV_END;
      DIV_ON: begin
        if (annul)              state_nxt = DIV_IDLE;
        else if (cnt_q == LAST) state_nxt = DIV_END;
      end
      DIV_END:    state_nxt = DIV_IDLE;
      default:    state_nxt = DIV_IDLE;
    endcase
  end

  // Outputs: stall through issue/BYZERO/ON, result only in an un-annulled END.
  always_comb begin
    busy      = (state_q != DIV_IDLE);
    stallreq  = 1'b0;
    whilo     = 1'b0;
    quotient  = '0;
    remainder = '0;
    case (state_q)
      DIV_IDLE:           stallreq = start && !annul;
      DIV_BYZERO, DIV_ON: stallreq = !annul;
      DIV_END: begin
        if (!annul) begin
          whilo = 1'b1;
          if (dz_q) begin
            quotient  = '1;
            remainder = a_q;
          end else begin
            quotient  = quo_fix;
            remainder = rem_fix;
          end
        end
      end
      default: ;
    endcase
  end

  // Operand latch at issue, then shift the remainder/quotient pair once per ON cycle.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      a_q   <= '0;
      b_q   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      sgn_q <= 1'b0;
      dz_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start && !annul) begin
            a_q   <= dividend;
            b_q   <= divisor;
            sgn_q <= signed_op;
            dz_q  <= (divisor == '0);
            rem_q <= '0;
            quo_q <= a_mag;
            cnt_q <= '0;
          end
        end
        DIV_ON: begin
          if (annul) begin
            cnt_q <= '0;
          end else begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Execute-stage multiply/divide unit: combinational MULT(U), two-cycle
// MADD/MSUB accumulate, iterative DIV(U) through ex_div, HI/LO output mux.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [DATA_W-1:0]  reg1_data_i,
  input  logic [DATA_W-1:0]  reg2_data_i,
  input  logic [DATA_W-1:0]  hi_i,
  input  logic [DATA_W-1:0]  lo_i,
  input  logic               annul_i,
  output logic               stallreq_o,
  output logic               whilo_o,
  output logic [DATA_W-1:0]  hi_o,
  output logic [DATA_W-1:0]  lo_o,
  output logic               busy_o
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  mdop_t              op;
  logic [PROD_W-1:0]  opa_ext, opb_ext, product, prod_q, acc_res;
  logic               phase_q;
  logic               div_busy, div_stall, div_whilo;
  logic [DATA_W-1:0]  div_quo, div_rem;

  assign op = decode_mdop(aluop_i);

  // Full-width product; sign extension to 2*DATA_W makes the truncated product exact.
  always_comb begin
    opa_ext = op.sgn ? {{DATA_W{reg1_data_i[DATA_W-1]}}, reg1_data_i} : {{DATA_W{1'b0}}, reg1_data_i};
    opb_ext = op.sgn ? {{DATA_W{reg2_data_i[DATA_W-1]}}, reg2_data_i} : {{DATA_W{1'b0}}, reg2_data_i};
    product = opa_ext * opb_ext;
    acc_res = op.sub ? ({hi_i, lo_i} - prod_q) : ({hi_i, lo_i} + prod_q);
  end

  // Accumulate phase: cycle 1 registers the product, cycle 2 always returns to phase 0.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      phase_q <= 1'b0;
      prod_q  <= '0;
    end else if (op.acc && !phase_q && !annul_i && !div_busy) begin
      phase_q <= 1'b1;
      prod_q  <= product;
    end else begin
      phase_q <= 1'b0;
    end
  end

  ex_div #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (op.div),
    .signed_op (op.sgn),
    .annul     (annul_i),
    .dividend  (reg1_data_i),
    .divisor   (reg2_data_i),
    .busy      (div_busy),
    .stallreq  (div_stall),
    .whilo     (div_whilo),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Output mux; an active divide owns the outputs until it leaves END.
  always_comb begin
    stallreq_o = 1'b0;
    whilo_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    busy_o     = 1'b0;
    if (rst != RST_ENABLE) begin
      busy_o = div_busy;
      if (div_busy || op.div) begin
        stallreq_o = div_stall;
        whilo_o    = div_whilo;
        hi_o       = div_rem;
        lo_o       = div_quo;
      end else if (op.mult) begin
        whilo_o      = 1'b1;
        {hi_o, lo_o} = product;
      end else if (op.acc && !annul_i) begin
        if (!phase_q) begin
          stallreq_o = 1'b1;
        end else begin
          whilo_o      = 1'b1;
          {hi_o, lo_o} = acc_res;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed literal cases plus a randomized stream,
// every cycle compared against a behavioural HI/LO model.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    aluop = EXE_NOP_OP;
  logic [W-1:0]  a = '0, b = '0, hi_in = '0, lo_in = '0;
  logic          annul = 1'b0;
  logic          stallreq_o, whilo_o, busy_o;
  logic [W-1:0]  hi_o, lo_o;

  ex_muldiv #(.DATA_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .aluop_i     (aluop),
    .reg1_data_i (a),
    .reg2_data_i (b),
    .hi_i        (hi_in),
    .lo_i        (lo_in),
    .annul_i     (annul),
    .stallreq_o  (stallreq_o),
    .whilo_o     (whilo_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: cycles left until the divide result, pending accumulate product.
  int           d_left = 0;
  logic [W-1:0] d_q = '0, d_r = '0;
  logic         madd_pend = 1'b0;
  logic [63:0]  madd_prod = '0;

  logic         exp_stall = 1'b0, exp_whilo = 1'b0, exp_busy = 1'b0;
  logic [W-1:0] exp_hi = '0, exp_lo = '0;

  function automatic bit is_div(input logic [7:0] op);
    return op == EXE_DIV_OP || op == EXE_DIVU_OP;
  endfunction
  function automatic bit is_mul(input logic [7:0] op);
    return op == EXE_MULT_OP || op == EXE_MULTU_OP;
  endfunction
  function automatic bit is_acc(input logic [7:0] op);
    return op == EXE_MADD_OP || op == EXE_MADDU_OP || op == EXE_MSUB_OP || op == EXE_MSUBU_OP;
  endfunction
  function automatic bit is_sgn(input logic [7:0] op);
    return op == EXE_MULT_OP || op == EXE_MADD_OP || op == EXE_MSUB_OP || op == EXE_DIV_OP;
  endfunction

  function automatic logic [63:0] full_product(input logic [7:0] op, input logic [W-1:0] x, y);
    longint p;
    if (is_sgn(op)) begin
      p = longint'($signed(x)) * longint'($signed(y));
      return 64'(p);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  // Quotient/remainder with truncating division; 64-bit arithmetic covers most-negative / -1.
  task automatic div_result(input logic [7:0] op, input logic [W-1:0] x, y,
                            output logic [W-1:0] q, output logic [W-1:0] r);
    longint lx, ly;
    if (y == 0) begin
      q = '1;
      r = x;
    end else if (is_sgn(op)) begin
      lx = longint'($signed(x));
      ly = longint'($signed(y));
      q  = 32'(lx / ly);
      r  = 32'(lx % ly);
    end else begin
      q = x / y;
      r = x % y;
    end
  endtask

  // Expected outputs for the cycle just driven, then advance the model.
  task automatic model_eval();
    logic [63:0] acc;
    exp_stall = 1'b0; exp_whilo = 1'b0; exp_busy = 1'b0; exp_hi = '0; exp_lo = '0;
    if (rst) begin
      d_left = 0;
      madd_pend = 1'b0;
    end else if (d_left > 0) begin
      exp_busy = 1'b1;
      madd_pend = 1'b0;
      if (annul) begin
        d_left = 0;
      end else if (d_left == 1) begin
        exp_whilo = 1'b1; exp_hi = d_r; exp_lo = d_q;
        d_left = 0;
      end else begin
        exp_stall = 1'b1;
        d_left--;
      end
    end else if (is_div(aluop)) begin
      madd_pend = 1'b0;
      if (!annul) begin
        exp_stall = 1'b1;
        div_result(aluop, a, b, d_q, d_r);
        d_left = (b == 0) ? 2 : W + 1;
      end
    end else if (is_mul(aluop)) begin
      madd_pend = 1'b0;
      exp_whilo = 1'b1;
      {exp_hi, exp_lo} = full_product(aluop, a, b);
    end else if (is_acc(aluop)) begin
      if (annul) begin
        madd_pend = 1'b0;
      end else if (madd_pend) begin
        acc = (aluop == EXE_MSUB_OP || aluop == EXE_MSUBU_OP) ? {hi_in, lo_in} - madd_prod
                                                              : {hi_in, lo_in} + madd_prod;
        exp_whilo = 1'b1;
        {exp_hi, exp_lo} = acc;
        madd_pend = 1'b0;
      end else begin
        exp_stall = 1'b1;
        madd_prod = full_product(aluop, a, b);
        madd_pend = 1'b1;
      end
    end else begin
      madd_pend = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // One cycle: drive just after the rising edge, return just after the falling edge.
  task automatic step(input logic [7:0] op, input logic [W-1:0] x, y, h, l,
                      input logic an, input logic r);
    @(posedge clk);
    #1;
    aluop = op; a = x; b = y; hi_in = h; lo_in = l; annul = an; rst = r;
    model_eval();
    @(negedge clk);
    #1;
  endtask

  task automatic run_div(input logic [7:0] op, input logic [W-1:0] x, y, output int n);
    step(op, x, y, $urandom, $urandom, 1'b0, 1'b0);
    n = 0;
    while (stallreq_o === 1'b1 && n < 80) begin
      n++;
      step(op, $urandom, $urandom, $urandom, $urandom, 1'b0, 1'b0);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("stallreq", 64'(stallreq_o), 64'(exp_stall));
    chk("whilo", 64'(whilo_o), 64'(exp_whilo));
    chk("busy", 64'(busy_o), 64'(exp_busy));
    chk("hi", 64'(hi_o), 64'(exp_hi));
    chk("lo", 64'(lo_o), 64'(exp_lo));
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int writes;
    logic [7:0] cur_op;
    logic [7:0] ops [10];
    logic [W-1:0] x, y;
    logic an, r;
    ops = '{EXE_MULT_OP, EXE_MULTU_OP, EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP,
            EXE_MSUBU_OP, EXE_DIV_OP, EXE_DIVU_OP, EXE_NOP_OP, 8'h21};

    // Reset state
    step(EXE_NOP_OP, '0, '0, '0, '0, 1'b0, 1'b1);
    step(EXE_DIV_OP, 32'd9, 32'd3, '0, '0, 1'b0, 1'b1);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_stall", 64'(stallreq_o), 0);
    chk("rst_whilo", 64'(whilo_o), 0);
    step(EXE_NOP_OP, '0, '0, '0, '0, 1'b0, 1'b0);
    chk("idle_busy", 64'(busy_o), 0);

    // MULT / MULTU
    step(EXE_MULT_OP, 32'hFFFFFFFF, 32'd2, '0, '0, 1'b0, 1'b0);
    chk("mult_hi", 64'(hi_o), 64'h0FFFFFFFF);
    chk("mult_lo", 64'(lo_o), 64'h0FFFFFFFE);
    chk("mult_stall", 64'(stallreq_o), 0);
    step(EXE_MULTU_OP, 32'hFFFFFFFF, 32'd2, '0, '0, 1'b0, 1'b0);
    chk("multu_hi", 64'(hi_o), 64'h1);
    chk("multu_lo", 64'(lo_o), 64'h0FFFFFFFE);

    // MADD two-cycle accumulate
    step(EXE_MADD_OP, 32'd3, 32'd4, 32'd0, 32'd5, 1'b0, 1'b0);
    chk("madd_c1_stall", 64'(stallreq_o), 1);
    chk("madd_c1_whilo", 64'(whilo_o), 0);
    step(EXE_MADD_OP, 32'd3, 32'd4, 32'd0, 32'd5, 1'b0, 1'b0);
    chk("madd_c2_whilo", 64'(whilo_o), 1);
    chk("madd_c2_hi", 64'(hi_o), 0);
    chk("madd_c2_lo", 64'(lo_o), 64'h11);

    // MSUBU wraps modulo 2^64
    step(EXE_MSUBU_OP, 32'd1, 32'd1, '0, '0, 1'b0, 1'b0);
    step(EXE_MSUBU_OP, 32'd1, 32'd1, '0, '0, 1'b0, 1'b0);
    chk("msubu_hi", 64'(hi_o), 64'h0FFFFFFFF);
    chk("msubu_lo", 64'(lo_o), 64'h0FFFFFFFF);

    // DIV -7 / 2
    run_div(EXE_DIV_OP, 32'hFFFFFFF9, 32'd2, n);
    chk("div_stall_cycles", 64'(n), 33);
    chk("div_lo", 64'(lo_o), 64'h0FFFFFFFD);
    chk("div_hi", 64'(hi_o), 64'h0FFFFFFFF);
    chk("div_whilo", 64'(whilo_o), 1);

    // DIVU by zero
    run_div(EXE_DIVU_OP, 32'd100, 32'd0, n);
    chk("dz_stall_cycles", 64'(n), 2);
    chk("dz_lo", 64'(lo_o), 64'h0FFFFFFFF);
    chk("dz_hi", 64'(hi_o), 64'h64);

    // Most-negative / -1
    run_div(EXE_DIV_OP, 32'h80000000, 32'hFFFFFFFF, n);
    chk("ovf_lo", 64'(lo_o), 64'h80000000);
    chk("ovf_hi", 64'(hi_o), 0);

    // Annul at issue suppresses the divide
    step(EXE_DIV_OP, 32'd50, 32'd5, '0, '0, 1'b1, 1'b0);
    chk("annul_issue_stall", 64'(stallreq_o), 0);
    step(EXE_NOP_OP, '0, '0, '0, '0, 1'b0, 1'b0);
    chk("annul_issue_busy", 64'(busy_o), 0);

    // Annul mid-divide, then a clean re-issue
    step(EXE_DIVU_OP, 32'd9, 32'd3, '0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) step(EXE_DIVU_OP, $urandom, $urandom, '0, '0, 1'b0, 1'b0);
    step(EXE_DIVU_OP, 32'd9, 32'd3, '0, '0, 1'b1, 1'b0);
    chk("annul_stall", 64'(stallreq_o), 0);
    chk("annul_whilo", 64'(whilo_o), 0);
    step(EXE_NOP_OP, '0, '0, '0, '0, 1'b0, 1'b0);
    chk("annul_next_busy", 64'(busy_o), 0);
    chk("annul_next_stall", 64'(stallreq_o), 0);
    run_div(EXE_DIVU_OP, 32'd9, 32'd3, n);
    chk("reissue_cycles", 64'(n), 33);
    chk("reissue_lo", 64'(lo_o), 3);
    chk("reissue_hi", 64'(hi_o), 0);

    // Reset mid-divide
    step(EXE_DIV_OP, 32'd1000, 32'd7, '0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) step(EXE_DIV_OP, 32'd1000, 32'd7, '0, '0, 1'b0, 1'b0);
    step(EXE_NOP_OP, '0, '0, '0, '0, 1'b0, 1'b1);
    chk("rstdiv_stall", 64'(stallreq_o), 0);
    step(EXE_NOP_OP, '0, '0, '0, '0, 1'b0, 1'b0);
    chk("rstdiv_busy", 64'(busy_o), 0);
    chk("rstdiv_stall2", 64'(stallreq_o), 0);
    chk("rstdiv_whilo", 64'(whilo_o), 0);
    writes = 0;
    for (int i = 0; i < 40; i++) begin
      step(EXE_NOP_OP, '0, '0, '0, '0, 1'b0, 1'b0);
      if (whilo_o !== 1'b0) writes++;
    end
    chk("rstdiv_late_writes", 64'(writes), 0);

    // Randomized stream: the op is held while the model expects a stall
    cur_op = EXE_NOP_OP;
    for (int i = 0; i < 3000; i++) begin
      if (!exp_stall) cur_op = ops[$urandom_range(0, 9)];
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = '0;
        1: y = 32'($urandom_range(1, 9));
        2: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        3: x = 32'($urandom_range(0, 200));
        default: ;
      endcase
      an = 1'b0;
      if ((is_div(cur_op) || (is_acc(cur_op) && !madd_pend)) && $urandom_range(0, 29) == 0) an = 1'b1;
      r = ($urandom_range(0, 399) == 0);
      step(cur_op, x, y, $urandom, $urandom, an, r);
    end

    step(EXE_NOP_OP, '0, '0, '0, '0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
